// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner arbiter for a shared 3:1 4-bit mux; watchdog under ARB_WATCHDOG_EN
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state;
    logic [1:0] last, p1, p2, win;
    logic       force_rel;
    always_comb begin
        p1  = (last == 2'd2) ? 2'd0 : last + 2'd1;
        p2  = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        win = req[p1] ? p1 : req[p2] ? p2 : last;
    end
`ifdef ARB_WATCHDOG_EN
    logic [7:0] hold;
    assign force_rel = (state == GRANT) && (hold == 8'(MAX_HOLD - 1)) && |(req & ~gnt);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold <= 8'd0;
        else if (state == IDLE)
            hold <= 8'd0;
        else if (hold != 8'hff)
            hold <= hold + 8'd1;
    end
`else
    assign force_rel = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 2'd2;
            gnt     <= 3'b000;
            sel     <= 2'b00;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (|req) begin
                    state <= GRANT;
                    last  <= win;
                    gnt   <= 3'd1 << win;
                    sel   <= (win == 2'd0) ? 2'b00 : {1'b1, win[1]};
                    busy  <= 1'b1;
                end
            end else if (!(|(req & gnt)) || force_rel) begin
                state   <= IDLE;
                gnt     <= 3'b000;
                sel     <= 2'b00;
                busy    <= 1'b0;
                timeout <= force_rel;
            end
        end
    end
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed scoreboard bench for mux_sel_arbiter (MAX_HOLD=4)
module tb_mux_sel_arbiter;
    typedef struct packed {
        logic [2:0] g;
        logic [1:0] s;
        logic       b;
        logic       t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy, timeout;
    int         n = 0;
    int         fails = 0;
    exp_t       sb[$];

    mux_sel_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n++;
            fails++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".gnt"}, gnt, e.g);
            chk({tag, ".sel"}, {1'b0, sel}, {1'b0, e.s});
            chk({tag, ".busy"}, {2'b0, busy}, {2'b0, e.b});
            chk({tag, ".timeout"}, {2'b0, timeout}, {2'b0, e.t});
        end
    endtask

    task automatic step(input string tag, input logic [2:0] r, input logic [2:0] g,
                        input logic [1:0] s, input logic b, input logic t);
        req = r;
        sb.push_back('{g: g, s: s, b: b, t: t});
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        req = 3'b000;
        rst = 1'b1;
        sb.push_back('{g: 3'b000, s: 2'b00, b: 1'b0, t: 1'b0});
        #1;
        compare(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset("reset");

        step("single0", 3'b001, 3'b001, 2'b00, 1'b1, 1'b0);
        step("single1", 3'b001, 3'b001, 2'b00, 1'b1, 1'b0);
        step("single2", 3'b001, 3'b001, 2'b00, 1'b1, 1'b0);
        step("single_rel", 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);
        step("single_idle", 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);

        do_reset("reset2");
        step("rr_a0", 3'b111, 3'b001, 2'b00, 1'b1, 1'b0);
        step("rr_a1", 3'b111, 3'b001, 2'b00, 1'b1, 1'b0);
        step("rr_ai", 3'b110, 3'b000, 2'b00, 1'b0, 1'b0);
        step("rr_b0", 3'b111, 3'b010, 2'b10, 1'b1, 1'b0);
        step("rr_b1", 3'b111, 3'b010, 2'b10, 1'b1, 1'b0);
        step("rr_bi", 3'b101, 3'b000, 2'b00, 1'b0, 1'b0);
        step("rr_c0", 3'b111, 3'b100, 2'b11, 1'b1, 1'b0);
        step("rr_c1", 3'b111, 3'b100, 2'b11, 1'b1, 1'b0);
        step("rr_ci", 3'b011, 3'b000, 2'b00, 1'b0, 1'b0);
        step("rr_d0", 3'b111, 3'b001, 2'b00, 1'b1, 1'b0);
        step("rr_d1", 3'b111, 3'b001, 2'b00, 1'b1, 1'b0);
        step("rr_end", 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);

        step("hold1_0", 3'b010, 3'b010, 2'b10, 1'b1, 1'b0);
        step("hold1_1", 3'b111, 3'b010, 2'b10, 1'b1, 1'b0);
        step("hold1_2", 3'b110, 3'b010, 2'b10, 1'b1, 1'b0);
        step("hold1_3", 3'b011, 3'b010, 2'b10, 1'b1, 1'b0);
        step("hold1_4", 3'b010, 3'b010, 2'b10, 1'b1, 1'b0);
        step("hold1_rel", 3'b101, 3'b000, 2'b00, 1'b0, 1'b0);
        step("hold1_idle", 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);

        step("src2_0", 3'b100, 3'b100, 2'b11, 1'b1, 1'b0);
        step("src2_1", 3'b100, 3'b100, 2'b11, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        sb.push_back('{g: 3'b000, s: 2'b00, b: 1'b0, t: 1'b0});
        #1;
        compare("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 3'b110, 3'b010, 2'b10, 1'b1, 1'b0);
        step("post_rst_rel", 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);

        do_reset("reset3");
        for (int i = 0; i < 4; i++)
            step($sformatf("wd_hold%0d", i), 3'b011, 3'b001, 2'b00, 1'b1, 1'b0);
`ifdef ARB_WATCHDOG_EN
        step("wd_timeout", 3'b011, 3'b000, 2'b00, 1'b0, 1'b1);
        step("wd_next", 3'b011, 3'b010, 2'b10, 1'b1, 1'b0);
`else
        for (int i = 4; i < 24; i++)
            step($sformatf("nowd_hold%0d", i), 3'b011, 3'b001, 2'b00, 1'b1, 1'b0);
`endif
        step("final_rel", 3'b000, 3'b000, 2'b00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
